// File: rtl/pwm_audio_encoder.sv
// Signed 16-bit sample stream to fixed-rate PWM with a one-entry holding buffer (valid/ready).
// Build option PWM_DITHER_EN adds first-order error feedback on the truncated duty fraction.
module pwm_audio_encoder #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int PWM_FREQ_HZ = 50_000,
  parameter int CNT_W       = 16,
  parameter int MIN_HIGH    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [15:0]      sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             pwm_out,
  output logic             frame_start,
  output logic             underrun,
  output logic [CNT_W-1:0] duty_out
);

  localparam int PERIOD = CLK_FREQ_HZ / PWM_FREQ_HZ;
  localparam int HALF   = PERIOD / 2;
  localparam int PW     = 16 + CNT_W;

  localparam logic [CNT_W-1:0]     PERIOD_M1 = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0]     HALF_C    = CNT_W'(HALF);
  localparam logic [CNT_W-1:0]     LO_C      = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0]     HI_C      = CNT_W'(PERIOD - MIN_HIGH);
  localparam logic signed [PW-1:0] HALF_S    = PW'(HALF);
  localparam logic signed [PW-1:0] LO_S      = PW'(MIN_HIGH);
  localparam logic signed [PW-1:0] HI_S      = PW'(PERIOD - MIN_HIGH);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t state;
  state_t state_nxt;
  logic   running;
  logic   starting;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] duty_nxt;
  logic [CNT_W-1:0] duty_calc;
  logic [15:0]      buf_dat;
  logic             buf_full;
  logic             accept;
  logic             boundary;
  logic             consume;

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (enable)  state_nxt = ST_RUN;
      ST_RUN:  if (!enable) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Dropping enable overrides both states; the idle->run edge opens a fresh 50% frame.
  always_comb begin
    running  = (state == ST_RUN) & enable;
    starting = (state == ST_IDLE) & enable;
  end

  assign sample_ready = enable & ~buf_full;
  assign accept       = sample_valid & sample_ready;
  assign boundary     = running & (cnt == PERIOD_M1);
  assign consume      = boundary & buf_full;

  assign prod = $signed({{CNT_W{buf_dat[15]}}, buf_dat}) * HALF_S;

`ifdef PWM_DITHER_EN
  logic [14:0] err_acc;
  logic [15:0] err_sum;

  // Carry out of the accumulated fraction bumps the duty by one clock.
  assign err_sum = {1'b0, err_acc} + {1'b0, prod[14:0]};
  assign raw     = HALF_S + (prod >>> 15) + $signed({{(PW-1){1'b0}}, err_sum[15]});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_acc <= '0;
    end else if (!enable) begin
      err_acc <= '0;
    end else if (consume) begin
      err_acc <= err_sum[14:0];
    end
  end
`else
  assign raw = HALF_S + (prod >>> 15);
`endif

  always_comb begin
    if (raw < LO_S) begin
      duty_calc = LO_C;
    end else if (raw > HI_S) begin
      duty_calc = HI_C;
    end else begin
      duty_calc = raw[CNT_W-1:0];
    end
  end

  // An empty buffer at the boundary repeats the previous duty.
  always_comb begin
    cnt_nxt  = '0;
    duty_nxt = HALF_C;
    if (running) begin
      cnt_nxt  = boundary ? '0 : cnt + CNT_W'(1);
      duty_nxt = consume ? duty_calc : duty_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      duty_out    <= HALF_C;
      pwm_out     <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      duty_out    <= duty_nxt;
      pwm_out     <= (starting | running) & (cnt_nxt < duty_nxt);
      frame_start <= starting | boundary;
      underrun    <= boundary & ~buf_full;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_full <= 1'b0;
      buf_dat  <= '0;
    end else begin
      if (!enable || consume) begin
        buf_full <= 1'b0;
      end else if (accept) begin
        buf_full <= 1'b1;
      end
      if (accept) begin
        buf_dat <= sample_in;
      end
    end
  end

endmodule

// File: tb/tb_pwm_audio_encoder.sv
// Scoreboard bench: a frame-level reference model predicts each PWM frame; a monitor checks them.
module tb_pwm_audio_encoder;

  localparam int CLK_HZ   = 1_000_000;
  localparam int PWM_HZ   = 5_000;
  localparam int CNT_W    = 16;
  localparam int MIN_HIGH = 2;
  localparam int P        = CLK_HZ / PWM_HZ;
  localparam int H        = P / 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic [15:0]      sample_in = '0;
  logic             sample_valid = 1'b0;
  logic             sample_ready;
  logic             pwm_out;
  logic             frame_start;
  logic             underrun;
  logic [CNT_W-1:0] duty_out;

  pwm_audio_encoder #(
    .CLK_FREQ_HZ(CLK_HZ),
    .PWM_FREQ_HZ(PWM_HZ),
    .CNT_W(CNT_W),
    .MIN_HIGH(MIN_HIGH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .sample_in(sample_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .pwm_out(pwm_out),
    .frame_start(frame_start),
    .underrun(underrun),
    .duty_out(duty_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int duty;
    bit und;
  } frame_t;

  frame_t exp_q[$];

  int n_checks = 0;
  int n_err = 0;

  // Reference model state: running flag, position in frame, buffered samples, duty, dither error.
  bit          m_run = 1'b0;
  int          m_pos = 0;
  int          m_buf[$];
  int          m_duty = H;
  int          m_err = 0;
  bit          have_pend = 1'b0;
  logic [15:0] pend = '0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Duty from the sample with plain arithmetic: floor(s*H/32768) around the midpoint, then clamp.
  task automatic ref_duty(input int s, output int d);
    int p;
    int q;
    int r;
    p = s * H;
    q = (p >= 0) ? p / 32768 : -((-p + 32767) / 32768);
    r = H + q;
`ifdef PWM_DITHER_EN
    m_err += p - q * 32768;
    if (m_err >= 32768) begin
      r++;
      m_err -= 32768;
    end
`endif
    if (r < MIN_HIGH) r = MIN_HIGH;
    if (r > P - MIN_HIGH) r = P - MIN_HIGH;
    d = r;
  endtask

  function automatic logic [15:0] rand_sample();
    case ($urandom_range(0, 9))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'h0000;
      3:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  // One clock of stimulus, entered and left at a falling edge.
  task automatic cycle(input bit en);
    bit     acc;
    frame_t f;
    enable       = en;
    sample_valid = have_pend;
    sample_in    = have_pend ? pend : 16'($urandom);
    #1;
    chk("sample_ready", int'(sample_ready), int'(en && m_buf.size() == 0));
    acc = en && have_pend && m_buf.size() == 0;
    @(posedge clk);
    if (!en) begin
      m_run  = 1'b0;
      m_pos  = 0;
      m_buf.delete();
      m_duty = H;
      m_err  = 0;
    end else if (!m_run) begin
      m_run = 1'b1;
      m_pos = 0;
      f.duty = m_duty;
      f.und  = 1'b0;
      exp_q.push_back(f);
    end else if (m_pos == P - 1) begin
      f.und = (m_buf.size() == 0);
      if (!f.und) ref_duty(m_buf.pop_front(), m_duty);
      f.duty = m_duty;
      exp_q.push_back(f);
      m_pos = 0;
    end else begin
      m_pos++;
    end
    if (acc) begin
      m_buf.push_back(int'($signed(pend)));
      have_pend = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit en);
    for (int i = 0; i < n; i++) cycle(en);
  endtask

  task automatic offer(input logic [15:0] v);
    have_pend = 1'b1;
    pend      = v;
  endtask

  task automatic run_until_acc(input int limit);
    for (int i = 0; i < limit && have_pend; i++) cycle(1'b1);
    chk("sample_accepted", int'(have_pend), 0);
    have_pend = 1'b0;
  endtask

  task automatic goto_pos(input int p);
    for (int i = 0; i < 2 * P && m_pos != p; i++) cycle(1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_pwm_out", int'(pwm_out), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    chk("rst_underrun", int'(underrun), 0);
    chk("rst_duty_out", int'(duty_out), H);
    chk("rst_sample_ready", int'(sample_ready), int'(enable));
    m_run  = 1'b0;
    m_pos  = 0;
    m_buf.delete();
    m_duty = H;
    m_err  = 0;
    have_pend    = 1'b0;
    sample_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : stim
    @(negedge clk);
    do_reset();
    // Idle stream: 50% frames with underrun on every boundary.
    run(3 * P + 5, 1'b1);
    // Single sample then repeat.
    goto_pos(50);
    offer(16'h4000);
    run_until_acc(4);
    run(2 * P, 1'b1);
    // Clamped extremes, one per frame.
    goto_pos(10);
    offer(16'h8000);
    run_until_acc(4);
    goto_pos(10);
    offer(16'h7FFF);
    run_until_acc(4);
    run(2 * P, 1'b1);
    // Back-to-back: second sample waits for the boundary.
    goto_pos(P - 20);
    offer(16'h2000);
    run_until_acc(4);
    offer(16'hE000);
    run_until_acc(P);
    run(2 * P, 1'b1);
    // Accept on the boundary cycle itself with an empty buffer.
    goto_pos(P - 1);
    offer(16'hC000);
    run_until_acc(2);
    run(2 * P, 1'b1);
    // Disable mid-frame with a sample buffered, then re-enable.
    goto_pos(30);
    offer(16'h6000);
    run_until_acc(4);
    goto_pos(90);
    run(5, 1'b0);
    run(P + 10, 1'b1);
    // Asynchronous reset mid-frame with a sample buffered.
    goto_pos(40);
    offer(16'h1234);
    run_until_acc(4);
    goto_pos(120);
    do_reset();
    run(P + 5, 1'b1);
    // Randomized traffic with occasional disable bursts.
    for (int k = 0; k < 20000; k++) begin
      if (!have_pend && $urandom_range(0, 149) == 0) offer(rand_sample());
      if ($urandom_range(0, 2999) == 0) run(int'($urandom_range(1, 5)), 1'b0);
      else cycle(1'b1);
    end
    run(3, 1'b0);
    chk("exp_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  // Monitor: each frame_start pops a predicted frame; the waveform shape is checked over the frame.
  initial begin : monitor
    bit     in_fr;
    bit     en_s;
    int     len;
    int     mism;
    int     spur;
    int     highs;
    frame_t cur;
    in_fr = 1'b0;
    len = 0;
    mism = 0;
    spur = 0;
    highs = 0;
    cur.duty = H;
    cur.und = 1'b0;
    forever begin
      @(posedge clk);
      en_s = enable;
      #1;
      if (!rst_n) begin
        in_fr = 1'b0;
        continue;
      end
      if (!en_s) begin
        if (in_fr) begin
          chk("trunc_shape_errs", mism, 0);
          chk("trunc_high", highs, (len < cur.duty) ? len : cur.duty);
          chk("spurious_underrun", spur, 0);
          in_fr = 1'b0;
        end
        chk("idle_pulses", int'({pwm_out, frame_start, underrun}), 0);
        chk("idle_duty_out", int'(duty_out), H);
        continue;
      end
      if (frame_start) begin
        if (in_fr) begin
          chk("frame_len", len, P);
          chk("frame_high", highs, cur.duty);
          chk("pwm_shape_errs", mism, 0);
          chk("spurious_underrun", spur, 0);
        end
        chk("frame_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          chk("underrun", int'(underrun), int'(cur.und));
          chk("duty_out", int'(duty_out), cur.duty);
          in_fr = 1'b1;
        end else begin
          in_fr = 1'b0;
        end
        len = 0;
        mism = 0;
        spur = 0;
        highs = 0;
      end else if (underrun) begin
        spur++;
      end
      if (in_fr) begin
        if (pwm_out != (len < cur.duty)) mism++;
        highs += int'(pwm_out);
        len++;
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", n_checks);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
